// File: rtl/banked_two_port_mem.sv
// banked_two_port_mem: simple dual-port memory with byte-granular writes and a
// clear engine that zeroes the whole array.
//
// Ports:
//   clk, rst            single clock, asynchronous active-high reset
//   ena, wea, addra,    write port: accepted when ena=1 and busy=0; only bytes
//   dina                with wea[i]=1 are updated
//   enb, addrb          read port: accepted when enb=1 and busy=0
//   doutb, doutb_valid  read data after RD_LATENCY edges; valid pulses once per read,
//                       doutb holds its last value otherwise
//   clr_req             start a clear pass (ignored while busy)
//   busy                clear engine active; user reads and writes are blocked
//
// Reset leaves the engine in CLEAR at row 0, so every release from reset is followed
// by a full clear pass before the array becomes usable.
module banked_two_port_mem #(
    parameter int unsigned BIT_LENGTH  = 64,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned RD_LATENCY  = 1,
    parameter int unsigned WRITE_FIRST = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    input  logic [BIT_LENGTH/8-1:0]  wea,
    input  logic [$clog2(DEPTH)-1:0] addra,
    input  logic [BIT_LENGTH-1:0]    dina,
    input  logic                     enb,
    input  logic [$clog2(DEPTH)-1:0] addrb,
    output logic [BIT_LENGTH-1:0]    doutb,
    output logic                     doutb_valid,
    input  logic                     clr_req,
    output logic                     busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned NB = BIT_LENGTH / 8;

    typedef enum logic {StIdle, StClear} state_e;

    state_e          state_q;
    logic [AW-1:0]   cnt_q;

    logic [BIT_LENGTH-1:0] mem_q [DEPTH];

    logic                  wr_acc;
    logic                  rd_acc;
    logic [BIT_LENGTH-1:0] wr_word;
    logic [BIT_LENGTH-1:0] rd_word;

    logic [BIT_LENGTH-1:0] s1_data_q;
    logic                  s1_vld_q;
    logic [BIT_LENGTH-1:0] dout_q;
    logic                  vld_q;

    assign busy   = (state_q == StClear);
    assign wr_acc = ena & ~busy;
    assign rd_acc = enb & ~busy;

    // Clear engine. The edge that zeroes the last row returns to idle, so busy is
    // high for exactly DEPTH cycles and cnt never starts a second pass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StClear;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (clr_req) begin
                        state_q <= StClear;
                        cnt_q   <= '0;
                    end
                end
                StClear: begin
                    if (cnt_q == AW'(DEPTH - 1)) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StClear;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Old word at the write address with the enabled bytes replaced.
    always_comb begin
        wr_word = mem_q[addra];
        for (int i = 0; i < NB; i++) begin
            if (wea[i]) begin
                wr_word[8*i +: 8] = dina[8*i +: 8];
            end
        end
    end

    // Storage carries no reset; the clear pass that follows every reset zeroes it.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem_q[cnt_q] <= '0;
        end else if (ena) begin
            mem_q[addra] <= wr_word;
        end
    end

    // Same-edge collision: write-first forwards the merged word to the reader.
    always_comb begin
        rd_word = mem_q[addrb];
        if ((WRITE_FIRST != 0) && wr_acc && (addra == addrb)) begin
            rd_word = wr_word;
        end
    end

    // Read pipeline. The array is sampled at the accepting edge; with two stages the
    // second stage only moves the already-captured word, so later writes and a clear
    // starting behind an in-flight read do not disturb it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_data_q <= '0;
            s1_vld_q  <= 1'b0;
            dout_q    <= '0;
            vld_q     <= 1'b0;
        end else begin
            s1_vld_q <= rd_acc;
            if (rd_acc) begin
                s1_data_q <= rd_word;
            end
            if (RD_LATENCY == 2) begin
                vld_q <= s1_vld_q;
                if (s1_vld_q) begin
                    dout_q <= s1_data_q;
                end
            end else begin
                vld_q <= rd_acc;
                if (rd_acc) begin
                    dout_q <= rd_word;
                end
            end
        end
    end

    assign doutb       = dout_q;
    assign doutb_valid = vld_q;

endmodule

// File: tb/tb_banked_two_port_mem.sv
// Bench for banked_two_port_mem: two instances share one stimulus stream, one with
// RD_LATENCY=1/WRITE_FIRST=1 (a) and one with RD_LATENCY=2/WRITE_FIRST=0 (b).
// A reference memory predicts each read; the result is queued with the cycle it is
// due and popped when that cycle's outputs are sampled.
module tb_banked_two_port_mem;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    typedef struct {
        int unsigned due;
        logic [31:0] data;
    } rd_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ena = 1'b0;
    logic          enb = 1'b0;
    logic          clr_req = 1'b0;
    logic [3:0]    wea = '0;
    logic [AW-1:0] addra = '0;
    logic [AW-1:0] addrb = '0;
    logic [31:0]   dina = '0;

    logic [31:0] doutb_a, doutb_b;
    logic        vld_a, vld_b, busy_a, busy_b;

    logic [31:0] mem_m [DEPTH];
    bit          m_busy;
    int unsigned m_cnt;
    int unsigned cyc;
    logic [31:0] last_a, last_b;
    rd_t         q_a[$];
    rd_t         q_b[$];

    int unsigned n_chk;
    int unsigned n_pass;

    always #5 clk = ~clk;

    banked_two_port_mem #(
        .BIT_LENGTH (32),
        .DEPTH      (16),
        .RD_LATENCY (1),
        .WRITE_FIRST(1)
    ) dut_a (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .wea        (wea),
        .addra      (addra),
        .dina       (dina),
        .enb        (enb),
        .addrb      (addrb),
        .doutb      (doutb_a),
        .doutb_valid(vld_a),
        .clr_req    (clr_req),
        .busy       (busy_a)
    );

    banked_two_port_mem #(
        .BIT_LENGTH (32),
        .DEPTH      (16),
        .RD_LATENCY (2),
        .WRITE_FIRST(0)
    ) dut_b (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .wea        (wea),
        .addra      (addra),
        .dina       (dina),
        .enb        (enb),
        .addrb      (addrb),
        .doutb      (doutb_b),
        .doutb_valid(vld_b),
        .clr_req    (clr_req),
        .busy       (busy_b)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s (cycle %0d): got %h, expected %h", tag, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    // Predict the effect of the coming edge from the inputs now applied, take the
    // edge, then compare everything the DUTs present after it.
    task automatic step();
        logic [31:0] rd_a;
        logic [31:0] rd_b;
        if (!rst) begin
            if (enb && !m_busy) begin
                rd_b = mem_m[addrb];
                rd_a = rd_b;
                if (ena && (addra == addrb)) rd_a = merge(mem_m[addra], dina, wea);
                q_a.push_back('{cyc + 1, rd_a});
                q_b.push_back('{cyc + 2, rd_b});
            end
            if (ena && !m_busy) mem_m[addra] = merge(mem_m[addra], dina, wea);
            if (m_busy) begin
                mem_m[m_cnt] = '0;
                if (m_cnt == DEPTH - 1) begin
                    m_busy = 1'b0;
                    m_cnt  = 0;
                end else begin
                    m_cnt++;
                end
            end else if (clr_req) begin
                m_busy = 1'b1;
                m_cnt  = 0;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        check("busy_a", 32'(busy_a), 32'(m_busy));
        check("busy_b", 32'(busy_b), 32'(m_busy));
        if (q_a.size() > 0 && q_a[0].due == cyc) begin
            check("valid_a", 32'(vld_a), 32'd1);
            check("data_a", doutb_a, q_a[0].data);
            last_a = q_a[0].data;
            void'(q_a.pop_front());
        end else begin
            check("idle_valid_a", 32'(vld_a), 32'd0);
            check("hold_a", doutb_a, last_a);
        end
        if (q_b.size() > 0 && q_b[0].due == cyc) begin
            check("valid_b", 32'(vld_b), 32'd1);
            check("data_b", doutb_b, q_b[0].data);
            last_b = q_b[0].data;
            void'(q_b.pop_front());
        end else begin
            check("idle_valid_b", 32'(vld_b), 32'd0);
            check("hold_b", doutb_b, last_b);
        end
    endtask

    // Asserted away from the clock edge; outputs must drop without waiting for one.
    task automatic do_reset(input int unsigned hold);
        rst = 1'b1;
        #1;
        m_busy = 1'b1;
        m_cnt  = 0;
        q_a.delete();
        q_b.delete();
        last_a = '0;
        last_b = '0;
        check("rst_doutb_a", doutb_a, 32'd0);
        check("rst_doutb_b", doutb_b, 32'd0);
        check("rst_valid_a", 32'(vld_a), 32'd0);
        check("rst_valid_b", 32'(vld_b), 32'd0);
        check("rst_busy_a", 32'(busy_a), 32'd1);
        repeat (hold) step();
        rst = 1'b0;
    endtask

    task automatic run_until_idle(input string tag);
        int unsigned n;
        n = 0;
        while (busy_a && n < 100) begin
            step();
            n++;
        end
        check(tag, n, 32'd16);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        ena   = 1'b1;
        addra = a;
        dina  = d;
        wea   = be;
        step();
        ena = 1'b0;
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++) begin
            enb   = 1'b1;
            addrb = AW'(i);
            step();
        end
        enb = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        int unsigned n;
        n_chk  = 0;
        n_pass = 0;
        cyc    = 0;
        m_busy = 1'b1;
        m_cnt  = 0;
        last_a = '0;
        last_b = '0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;

        // Reset to ready, then every row reads back zero.
        #2;
        do_reset(2);
        run_until_idle("post_reset_busy_len");
        read_all();

        // Byte enables.
        wr(4'd3, 32'hAABBCCDD, 4'b1111);
        wr(4'd3, 32'h11223344, 4'b0101);
        enb = 1'b1; addrb = 4'd3; step(); enb = 1'b0;
        repeat (2) step();

        // Same-edge collision on a zero row.
        ena = 1'b1; wea = 4'b0011; addra = 4'd5; dina = 32'hFFFFFFFF;
        enb = 1'b1; addrb = 4'd5;
        step();
        ena = 1'b0; enb = 1'b0;
        repeat (2) step();

        // Back-to-back reads, then a write landing the edge after a read of that row.
        wr(4'd1, 32'h01010101, 4'hF);
        wr(4'd2, 32'h02020202, 4'hF);
        wr(4'd3, 32'h03030303, 4'hF);
        for (int i = 1; i <= 3; i++) begin
            enb = 1'b1; addrb = AW'(i); step();
        end
        addrb = 4'd7; step();
        enb = 1'b0;
        wr(4'd7, 32'h12345678, 4'hF);
        enb = 1'b1; addrb = 4'd7; step(); enb = 1'b0;
        repeat (3) step();

        // Random traffic with occasional clear requests.
        for (int i = 0; i < 80; i++) begin
            ena     = 1'($urandom_range(0, 1));
            enb     = 1'($urandom_range(0, 1));
            wea     = 4'($urandom);
            addra   = AW'($urandom);
            addrb   = AW'($urandom);
            dina    = $urandom;
            clr_req = ($urandom_range(0, 29) == 0);
            step();
        end
        ena = 1'b0; enb = 1'b0; clr_req = 1'b0;
        while (busy_a && n < 100) begin step(); n++; end
        for (int i = 0; i < DEPTH; i++) wr(AW'(i), 32'hA5000000 | 32'(i), 4'hF);

        // Clear requested together with a write and read; everything blocked during it.
        ena = 1'b1; wea = 4'hF; addra = 4'd2; dina = 32'hCAFEF00D;
        enb = 1'b1; addrb = 4'd2; clr_req = 1'b1;
        step();
        n = 0;
        while (busy_a && n < 100) begin
            dina  = $urandom;
            addra = AW'($urandom);
            addrb = AW'($urandom);
            step();
            n++;
        end
        ena = 1'b0; enb = 1'b0; clr_req = 1'b0;
        check("blocked_busy_len", n, 32'd16);
        read_all();

        // Reset in the middle of a pass restarts it from row 0.
        for (int i = 0; i < DEPTH; i++) wr(AW'(i), 32'h5A5A0000 | 32'(i), 4'hF);
        clr_req = 1'b1; step(); clr_req = 1'b0;
        repeat (6) step();
        do_reset(2);
        run_until_idle("mid_clear_busy_len");
        read_all();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
